// File: rtl/y1_0_drv.sv
// y1_0_drv: issues 16-bit stimulus vectors (exhaustive sweep or LFSR walk),
// realigns the device's delayed match bit and tallies hits for one run.
module y1_0_drv #(
  parameter int RESP_LAT = 1,
  parameter int NUM_VEC  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] seed,
  output logic [15:0] vec,
  output logic        vec_valid,
  input  logic        resp,
  output logic        busy,
  output logic        done,
  output logic [16:0] hit_cnt,
  output logic [15:0] first_hit,
  output logic        found
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [15:0] vec_q, vec_d;
  logic [15:0] idx_q, idx_d;
  logic [2:0]  drain_q, drain_d;
  logic [16:0] hit_q, hit_d;
  logic [15:0] first_q, first_d;
  logic        found_q, found_d;

  logic        run_w;
  logic        last_vec;
  logic [15:0] lfsr_next;
  logic [15:0] seed_fix;
  logic [15:0] dly_vec;
  logic        dly_valid;

  assign run_w     = (state_q == RUN);
  assign lfsr_next = {vec_q[14:0], vec_q[15] ^ vec_q[13] ^ vec_q[12] ^ vec_q[10]};
  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  assign seed_fix  = (seed == 16'h0000) ? 16'h0001 : seed;
  assign last_vec  = mode_q ? (idx_q == 16'(NUM_VEC - 1)) : (vec_q == 16'hFFFF);

  // Delay line pairs each issued vector with the resp that arrives RESP_LAT later.
  generate
    if (RESP_LAT == 0) begin : g_no_dly
      assign dly_vec   = vec_q;
      assign dly_valid = run_w;
    end else begin : g_dly
      logic [15:0] dl_vec_q [RESP_LAT];
      logic        dl_val_q [RESP_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RESP_LAT; i++) begin
            dl_vec_q[i] <= 16'h0000;
            dl_val_q[i] <= 1'b0;
          end
        end else begin
          dl_vec_q[0] <= vec_q;
          dl_val_q[0] <= run_w;
          for (int i = 1; i < RESP_LAT; i++) begin
            dl_vec_q[i] <= dl_vec_q[i-1];
            dl_val_q[i] <= dl_val_q[i-1];
          end
        end
      end

      assign dly_vec   = dl_vec_q[RESP_LAT-1];
      assign dly_valid = dl_val_q[RESP_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    hit_d   = hit_q;
    first_d = first_q;
    found_d = found_q;

    // The last delayed sample lands on the same edge that leaves DRAIN/RUN.
    if (dly_valid && resp) begin
      hit_d = hit_q + 17'd1;
      if (!found_q) begin
        first_d = dly_vec;
        found_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          vec_d   = mode ? seed_fix : 16'h0000;
          idx_d   = 16'h0000;
          hit_d   = 17'd0;
          first_d = 16'h0000;
          found_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_vec) begin
          if (RESP_LAT == 0) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
            drain_d = 3'(RESP_LAT - 1);
          end
        end else begin
          vec_d = mode_q ? lfsr_next : (vec_q + 16'd1);
          idx_d = idx_q + 16'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      vec_q   <= 16'h0000;
      idx_q   <= 16'h0000;
      drain_q <= 3'd0;
      hit_q   <= 17'd0;
      first_q <= 16'h0000;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      hit_q   <= hit_d;
      first_q <= first_d;
      found_q <= found_d;
    end
  end

  assign vec       = vec_q;
  assign vec_valid = run_w;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign hit_cnt   = hit_q;
  assign first_hit = first_q;
  assign found     = found_q;

endmodule

// File: tb/tb_y1_0_drv.sv
// Directed bench for y1_0_drv: three instances (RESP_LAT 1, 0, 7; NUM_VEC 4)
// share stimulus, each paired with a responder modelling its latency.
module tb_y1_0_drv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode_i = 1'b0;
  logic [15:0] seed_i = 16'h0000;

  logic [15:0] vec_w   [3];
  logic        vv_w    [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        found_w [3];
  logic        resp_w  [3];
  logic [16:0] hit_w   [3];
  logic [15:0] first_w [3];

  int resp_mode = 2;
  int n_pass = 0;
  int n_total = 0;

  int          done_tot [3];
  int          busy_tot [3];
  int          done_base [3];
  int          busy_base [3];
  logic [16:0] hit_dn   [3];
  logic [15:0] first_dn [3];
  logic        found_dn [3];
  logic [15:0] hist [3][8];

  y1_0_drv #(.RESP_LAT(1), .NUM_VEC(4)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode_i), .seed(seed_i),
    .vec(vec_w[0]), .vec_valid(vv_w[0]), .resp(resp_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .hit_cnt(hit_w[0]), .first_hit(first_w[0]), .found(found_w[0]));

  y1_0_drv #(.RESP_LAT(0), .NUM_VEC(4)) u_dut_l0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode_i), .seed(seed_i),
    .vec(vec_w[1]), .vec_valid(vv_w[1]), .resp(resp_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .hit_cnt(hit_w[1]), .first_hit(first_w[1]), .found(found_w[1]));

  y1_0_drv #(.RESP_LAT(7), .NUM_VEC(4)) u_dut_l7 (
    .clk(clk), .rst(rst), .start(start), .mode(mode_i), .seed(seed_i),
    .vec(vec_w[2]), .vec_valid(vv_w[2]), .resp(resp_w[2]), .busy(busy_w[2]),
    .done(done_w[2]), .hit_cnt(hit_w[2]), .first_hit(first_w[2]), .found(found_w[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
  endfunction

  // Device model: 0 = match set {462C,462D,462E}, 1 = always match, else never.
  function automatic logic rsp(input logic [15:0] v, input int m);
    case (m)
      0:       return (v == 16'h462C) || (v == 16'h462D) || (v == 16'h462E);
      1:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      hist[k][0] <= vec_w[k];
      for (int j = 1; j < 8; j++) hist[k][j] <= hist[k][j-1];
    end
  end

  assign resp_w[0] = rsp(hist[0][0], resp_mode);
  assign resp_w[1] = rsp(vec_w[1], resp_mode);
  assign resp_w[2] = rsp(hist[2][6], resp_mode);

  // Counts busy cycles and done pulses; captures results while done is high.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy_w[k]) busy_tot[k] <= busy_tot[k] + 1;
      if (done_w[k]) begin
        done_tot[k] <= done_tot[k] + 1;
        hit_dn[k]   <= hit_w[k];
        first_dn[k] <= first_w[k];
        found_dn[k] <= found_w[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int k = 0; k < 3; k++) begin
      done_base[k] = done_tot[k];
      busy_base[k] = busy_tot[k];
    end
  endtask

  task automatic begin_run(input logic m, input logic [15:0] s);
    snap();
    mode_i = m;
    seed_i = s;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_runs(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_tot[0] != done_base[0] && done_tot[1] != done_base[1] &&
          done_tot[2] != done_base[2]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({vec_w[k], vv_w[k], busy_w[k], done_w[k]} !== 19'd0)
        $display("FAIL reset_outputs dut%0d: got vec=%h valid=%b busy=%b done=%b required all zero", k, vec_w[k], vv_w[k], busy_w[k], done_w[k]);
      else n_pass++;
      n_total++;
      if ({hit_w[k], first_w[k], found_w[k]} !== 34'd0)
        $display("FAIL reset_results dut%0d: got hit=%0d first=%h found=%b required all zero", k, hit_w[k], first_w[k], found_w[k]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  // Starts on the very first cycle after reset release.
  task automatic test_lfsr_seq();
    logic [15:0] exp_v [4];
    bit ok;
    exp_v[0] = 16'h0001; exp_v[1] = 16'h0002; exp_v[2] = 16'h0004; exp_v[3] = 16'h0008;
    resp_mode = 2;
    begin_run(1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if ({vv_w[k], vec_w[k]} !== {1'b1, exp_v[i]})
          $display("FAIL lfsr_vec%0d dut%0d: got valid=%b vec=%h required valid=1 vec=%h", i, k, vv_w[k], vec_w[k], exp_v[i]);
        else n_pass++;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({vv_w[k], vec_w[k], busy_w[k]} !== {1'b0, 16'h0008, (lat_of(k) != 0)})
        $display("FAIL after_last dut%0d: got valid=%b vec=%h busy=%b required valid=0 vec=0008 busy=%b", k, vv_w[k], vec_w[k], busy_w[k], (lat_of(k) != 0));
      else n_pass++;
    end
    n_total++;
    if (done_w[1] !== 1'b1) $display("FAIL lat0_direct_done: got done=%b required 1", done_w[1]);
    else n_pass++;
    wait_runs(60, ok);
    n_total++;
    if (!ok) $display("FAIL lfsr_timeout: got no done within 60 cycles required done");
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({hit_dn[k], first_dn[k], found_dn[k]} !== 34'd0)
        $display("FAIL lfsr_nohit dut%0d: got hit=%0d first=%h found=%b required 0 0000 0", k, hit_dn[k], first_dn[k], found_dn[k]);
      else n_pass++;
      n_total++;
      if (busy_tot[k] - busy_base[k] !== 4 + lat_of(k))
        $display("FAIL lfsr_busy dut%0d: got %0d cycles required %0d", k, busy_tot[k] - busy_base[k], 4 + lat_of(k));
      else n_pass++;
    end
  endtask

  task automatic test_always_hit();
    bit ok;
    resp_mode = 1;
    begin_run(1'b1, 16'hACE1);
    n_total++;
    if (vec_w[2] !== 16'hACE1) $display("FAIL seed_vec: got %h required ACE1", vec_w[2]);
    else n_pass++;
    tick();
    n_total++;
    if (vec_w[2] !== 16'h59C3) $display("FAIL lfsr_step: got %h required 59C3", vec_w[2]);
    else n_pass++;
    wait_runs(60, ok);
    n_total++;
    if (!ok) $display("FAIL allhit_timeout: got no done within 60 cycles required done");
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({hit_dn[k], first_dn[k], found_dn[k]} !== {17'd4, 16'hACE1, 1'b1})
        $display("FAIL allhit_result dut%0d: got hit=%0d first=%h found=%b required 4 ACE1 1", k, hit_dn[k], first_dn[k], found_dn[k]);
      else n_pass++;
    end
  endtask

  task automatic test_start_held();
    bit ok;
    resp_mode = 2;
    snap();
    mode_i = 1'b1;
    seed_i = 16'h0003;
    start  = 1'b1;
    repeat (6) tick();
    start  = 1'b0;
    wait_runs(60, ok);
    repeat (20) tick();
    n_total++;
    if (!ok) $display("FAIL held_timeout: got no done within 60 cycles required done");
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (done_tot[k] - done_base[k] !== 1)
        $display("FAIL held_done_count dut%0d: got %0d pulses required 1", k, done_tot[k] - done_base[k]);
      else n_pass++;
      n_total++;
      if (busy_tot[k] - busy_base[k] !== 4 + lat_of(k))
        $display("FAIL held_busy dut%0d: got %0d cycles required %0d", k, busy_tot[k] - busy_base[k], 4 + lat_of(k));
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    resp_mode = 1;
    begin_run(1'b0, 16'h0000);
    repeat (99) tick();
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({vec_w[k], hit_w[k]} !== {16'd99, 17'(99 - lat_of(k))})
        $display("FAIL midrun_progress dut%0d: got vec=%0d hit=%0d required vec=99 hit=%0d", k, vec_w[k], hit_w[k], 99 - lat_of(k));
      else n_pass++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({busy_w[k], vv_w[k], vec_w[k], hit_w[k], found_w[k]} !== 36'd0)
        $display("FAIL midrun_abort dut%0d: got busy=%b valid=%b vec=%h hit=%0d found=%b required all zero", k, busy_w[k], vv_w[k], vec_w[k], hit_w[k], found_w[k]);
      else n_pass++;
    end
    repeat (12) tick();
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({done_tot[k] - done_base[k], busy_w[k]} !== {32'd0, 1'b0})
        $display("FAIL midrun_no_done dut%0d: got %0d pulses busy=%b required 0 pulses busy=0", k, done_tot[k] - done_base[k], busy_w[k]);
      else n_pass++;
    end
  endtask

  task automatic test_exhaustive();
    bit ok;
    resp_mode = 0;
    begin_run(1'b0, 16'h1234);
    n_total++;
    if ({vv_w[0], vec_w[0]} !== {1'b1, 16'h0000})
      $display("FAIL exh_first: got valid=%b vec=%h required valid=1 vec=0000", vv_w[0], vec_w[0]);
    else n_pass++;
    tick();
    n_total++;
    if (vec_w[0] !== 16'h0001) $display("FAIL exh_second: got %h required 0001", vec_w[0]);
    else n_pass++;
    wait_runs(70000, ok);
    n_total++;
    if (!ok) $display("FAIL exh_timeout: got no done within 70000 cycles required done");
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if ({hit_dn[k], first_dn[k], found_dn[k]} !== {17'd3, 16'h462C, 1'b1})
        $display("FAIL exh_result dut%0d: got hit=%0d first=%h found=%b required 3 462C 1", k, hit_dn[k], first_dn[k], found_dn[k]);
      else n_pass++;
      n_total++;
      if (busy_tot[k] - busy_base[k] !== 65536 + lat_of(k))
        $display("FAIL exh_busy dut%0d: got %0d cycles required %0d", k, busy_tot[k] - busy_base[k], 65536 + lat_of(k));
      else n_pass++;
      n_total++;
      if ({hit_w[k], first_w[k], found_w[k]} !== {17'd3, 16'h462C, 1'b1})
        $display("FAIL exh_hold dut%0d: got hit=%0d first=%h found=%b required 3 462C 1", k, hit_w[k], first_w[k], found_w[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_seq();
    test_always_hit();
    test_start_held();
    test_reset_midrun();
    test_exhaustive();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
